// File: rtl/sub_16bit_seq.sv
// Multi-cycle subtractor: a - b - bin, one CHUNK-bit slice per clock, handshaked.
// Optional zero-result flag enabled by defining SUB16_ZERO_FLAG_EN.
module sub_16bit_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
`ifdef SUB16_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK:0]   sub_k;
  logic [WIDTH-1:0] diff_nxt;
  logic             ovf_nxt;

  // Top bit of the widened slice difference is the borrow into the next slice.
  always_comb begin
    a_k      = a_q[idx*CHUNK +: CHUNK];
    b_k      = b_q[idx*CHUNK +: CHUNK];
    sub_k    = {1'b0, a_k}
             - {1'b0, b_k}
             - {{CHUNK{1'b0}}, borrow_q};
    diff_nxt = diff;
    diff_nxt[idx*CHUNK +: CHUNK] = sub_k[CHUNK-1:0];
    ovf_nxt  = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
             & (diff_nxt[WIDTH-1] ^ a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      overflow  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      borrow_q  <= 1'b0;
      idx       <= '0;
`ifdef SUB16_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          diff     <= diff_nxt;
          borrow_q <= sub_k[CHUNK];
          idx      <= idx + ONE;
          if (idx == LAST) begin
            bout      <= sub_k[CHUNK];
            overflow  <= ovf_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SUB16_ZERO_FLAG_EN
            zero      <= ~|diff_nxt;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
